// File: rtl/power_mode_controller_pkg.sv
// Shared definitions for the power mode controller: per-domain state
// encoding and the domain index used on every 3-bit vector.
package power_mode_controller_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      DRAIN  = 2'd1,
      OFF    = 2'd2,
      WAKE   = 2'd3
   } pwr_state_t;

   localparam int DOM_RT      = 0;
   localparam int DOM_GP      = 1;
   localparam int DOM_PERIPH  = 2;
   localparam int NUM_DOMAINS = 3;

endpackage

// File: rtl/power_mode_controller_domain_pwr_fsm.sv
// Per-domain power FSM: ACTIVE -> DRAIN -> OFF -> WAKE -> ACTIVE, with a
// drain timeout counter and a wake settle counter. All outputs registered.
module domain_pwr_fsm
   import power_mode_controller_pkg::*;
#(
   parameter int unsigned WAKE_SETTLE_CYCLES = 16,
   parameter int unsigned DRAIN_TIMEOUT      = 1024
)
(
   input  logic       clk_gp_100mhz,
   input  logic       rst_n_gp,
   input  logic       force_active,
   input  logic       sleep_req,
   input  logic       sleep_permit,
   input  logic       idle,
   input  logic       wake_evt,
   output pwr_state_t state,
   output logic       power_down,
   output logic       sleep_ack,
   output logic       sleep_nack,
   output logic       wake_done
);

   // Counters hold at most PARAM-1, so $clog2(PARAM) bits never wrap.
   localparam int unsigned DRAIN_W  = $clog2(DRAIN_TIMEOUT);
   localparam int unsigned SETTLE_W = (WAKE_SETTLE_CYCLES > 1) ? $clog2(WAKE_SETTLE_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(DRAIN_TIMEOUT - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(WAKE_SETTLE_CYCLES - 1);

   logic [DRAIN_W-1:0]  drain_cnt;
   logic [SETTLE_W-1:0] settle_cnt;

   // State transitions, counters and registered status pulses.
   always_ff @(posedge clk_gp_100mhz or negedge rst_n_gp) begin
      if (!rst_n_gp) begin
         state      <= ACTIVE;
         drain_cnt  <= '0;
         settle_cnt <= '0;
         power_down <= 1'b0;
         sleep_ack  <= 1'b0;
         sleep_nack <= 1'b0;
         wake_done  <= 1'b0;
      end else begin
         sleep_ack  <= 1'b0;
         sleep_nack <= 1'b0;
         wake_done  <= 1'b0;
         if (force_active) begin
            // Clocks not trustworthy: everything back to ACTIVE, refuse sleep.
            state      <= ACTIVE;
            drain_cnt  <= '0;
            settle_cnt <= '0;
            power_down <= 1'b0;
            sleep_nack <= sleep_req;
         end else begin
            case (state)
               ACTIVE: begin
                  power_down <= 1'b0;
                  if (sleep_req) begin
                     if (sleep_permit) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                     end else begin
                        sleep_nack <= 1'b1;
                     end
                  end
               end
               DRAIN: begin
                  // Wake beats idle: a pending wake aborts the sleep.
                  if (wake_evt) begin
                     state      <= ACTIVE;
                     sleep_nack <= 1'b1;
                  end else if (idle) begin
                     state      <= OFF;
                     power_down <= 1'b1;
                     sleep_ack  <= 1'b1;
                  end else if (drain_cnt == DRAIN_LAST) begin
                     state      <= ACTIVE;
                     sleep_nack <= 1'b1;
                  end else begin
                     drain_cnt <= drain_cnt + 1'b1;
                  end
               end
               OFF: begin
                  if (wake_evt) begin
                     state      <= WAKE;
                     power_down <= 1'b0;
                     settle_cnt <= '0;
                  end
               end
               WAKE: begin
                  if (settle_cnt == SETTLE_LAST) begin
                     state     <= ACTIVE;
                     wake_done <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt + 1'b1;
                  end
               end
               default: begin
                  state      <= ACTIVE;
                  power_down <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/power_mode_controller.sv
// Power mode controller for RT, GP and PERIPH domains. Holds the
// cross-domain rules: PERIPH may only sleep once RT and GP are OFF, PERIPH
// follows RT/GP out of OFF, and loss of clock stability overrides all.
module power_mode_controller
   import power_mode_controller_pkg::*;
#(
   parameter int unsigned WAKE_SETTLE_CYCLES = 16,
   parameter int unsigned DRAIN_TIMEOUT      = 1024
)
(
   input  logic       clk_gp_100mhz,
   input  logic       rst_n_gp,
   input  logic       clocks_stable,
   input  logic [2:0] sleep_req,
   input  logic [2:0] idle,
   input  logic [2:0] wake_evt,
   output logic [2:0] power_down,
   output logic [2:0] sleep_ack,
   output logic [2:0] sleep_nack,
   output logic [2:0] wake_done,
   output logic [5:0] pwr_state
);

   pwr_state_t st_rt;
   pwr_state_t st_gp;
   pwr_state_t st_periph;
   logic       force_active;
   logic       periph_permit;
   logic       rt_wake_start;
   logic       gp_wake_start;
   logic       periph_wake;

   assign force_active  = ~clocks_stable;
   assign periph_permit = (st_rt == OFF) && (st_gp == OFF);

   // RT/GP leaving OFF this cycle drags PERIPH along (or aborts its drain).
   assign rt_wake_start = clocks_stable && (st_rt == OFF) && wake_evt[DOM_RT];
   assign gp_wake_start = clocks_stable && (st_gp == OFF) && wake_evt[DOM_GP];
   assign periph_wake   = wake_evt[DOM_PERIPH] | rt_wake_start | gp_wake_start;

   assign pwr_state = {st_periph, st_gp, st_rt};

   domain_pwr_fsm #(
      .WAKE_SETTLE_CYCLES (WAKE_SETTLE_CYCLES),
      .DRAIN_TIMEOUT      (DRAIN_TIMEOUT)
   ) u_rt (
      .clk_gp_100mhz (clk_gp_100mhz),
      .rst_n_gp      (rst_n_gp),
      .force_active  (force_active),
      .sleep_req     (sleep_req[DOM_RT]),
      .sleep_permit  (1'b1),
      .idle          (idle[DOM_RT]),
      .wake_evt      (wake_evt[DOM_RT]),
      .state         (st_rt),
      .power_down    (power_down[DOM_RT]),
      .sleep_ack     (sleep_ack[DOM_RT]),
      .sleep_nack    (sleep_nack[DOM_RT]),
      .wake_done     (wake_done[DOM_RT])
   );

   domain_pwr_fsm #(
      .WAKE_SETTLE_CYCLES (WAKE_SETTLE_CYCLES),
      .DRAIN_TIMEOUT      (DRAIN_TIMEOUT)
   ) u_gp (
      .clk_gp_100mhz (clk_gp_100mhz),
      .rst_n_gp      (rst_n_gp),
      .force_active  (force_active),
      .sleep_req     (sleep_req[DOM_GP]),
      .sleep_permit  (1'b1),
      .idle          (idle[DOM_GP]),
      .wake_evt      (wake_evt[DOM_GP]),
      .state         (st_gp),
      .power_down    (power_down[DOM_GP]),
      .sleep_ack     (sleep_ack[DOM_GP]),
      .sleep_nack    (sleep_nack[DOM_GP]),
      .wake_done     (wake_done[DOM_GP])
   );

   domain_pwr_fsm #(
      .WAKE_SETTLE_CYCLES (WAKE_SETTLE_CYCLES),
      .DRAIN_TIMEOUT      (DRAIN_TIMEOUT)
   ) u_periph (
      .clk_gp_100mhz (clk_gp_100mhz),
      .rst_n_gp      (rst_n_gp),
      .force_active  (force_active),
      .sleep_req     (sleep_req[DOM_PERIPH]),
      .sleep_permit  (periph_permit),
      .idle          (idle[DOM_PERIPH]),
      .wake_evt      (periph_wake),
      .state         (st_periph),
      .power_down    (power_down[DOM_PERIPH]),
      .sleep_ack     (sleep_ack[DOM_PERIPH]),
      .sleep_nack    (sleep_nack[DOM_PERIPH]),
      .wake_done     (wake_done[DOM_PERIPH])
   );

endmodule

// File: tb/tb_power_mode_controller.sv
// Scoreboard bench for power_mode_controller: the driver predicts each
// cycle's outputs with a behavioural model and queues them; the monitor
// pops one expectation per clock and compares.
module tb_power_mode_controller;

   localparam int SETTLE  = 16;
   localparam int TIMEOUT = 8;
   localparam int S_ACT = 0, S_DRN = 1, S_OFF = 2, S_WAK = 3;

   typedef struct packed {
      logic [5:0] st;
      logic [2:0] pd;
      logic [2:0] ack;
      logic [2:0] nack;
      logic [2:0] done;
   } exp_t;

   logic       clk_gp_100mhz;
   logic       rst_n_gp;
   logic       clocks_stable;
   logic [2:0] sleep_req, idle, wake_evt;
   logic [2:0] power_down, sleep_ack, sleep_nack, wake_done;
   logic [5:0] pwr_state;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   drv_done = 0;

   // Model: mode per domain and remaining-cycle budgets.
   int   m_mode[3];
   int   m_budget[3];
   logic [2:0] m_pd;

   power_mode_controller #(
      .WAKE_SETTLE_CYCLES (SETTLE),
      .DRAIN_TIMEOUT      (TIMEOUT)
   ) dut (
      .clk_gp_100mhz (clk_gp_100mhz),
      .rst_n_gp      (rst_n_gp),
      .clocks_stable (clocks_stable),
      .sleep_req     (sleep_req),
      .idle          (idle),
      .wake_evt      (wake_evt),
      .power_down    (power_down),
      .sleep_ack     (sleep_ack),
      .sleep_nack    (sleep_nack),
      .wake_done     (wake_done),
      .pwr_state     (pwr_state)
   );

   initial clk_gp_100mhz = 1'b0;
   always #5 clk_gp_100mhz = ~clk_gp_100mhz;

   task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s @%0t got=%0h expected=%0h", name, $time, got, want);
      end
   endtask

   // Predict the outputs seen after the next rising edge.
   function automatic exp_t model_step(input logic [2:0] sr, input logic [2:0] id,
                                       input logic [2:0] we, input logic cs, input logic rn);
      exp_t e;
      bit   periph_ok, follow;
      e = '0;
      if (!rn) begin
         for (int i = 0; i < 3; i++) begin
            m_mode[i] = S_ACT; m_budget[i] = 0;
         end
         m_pd = '0;
      end else if (!cs) begin
         for (int i = 0; i < 3; i++) begin
            m_mode[i] = S_ACT; m_budget[i] = 0;
         end
         m_pd   = '0;
         e.nack = sr;
      end else begin
         periph_ok = (m_mode[0] == S_OFF) && (m_mode[1] == S_OFF);
         follow    = (m_mode[0] == S_OFF && we[0]) || (m_mode[1] == S_OFF && we[1]);
         for (int i = 0; i < 3; i++) begin
            bit w;
            w = we[i] || (i == 2 && follow);
            if (m_mode[i] == S_ACT) begin
               if (sr[i]) begin
                  if (i != 2 || periph_ok) begin
                     m_mode[i] = S_DRN; m_budget[i] = TIMEOUT;
                  end else e.nack[i] = 1'b1;
               end
            end else if (m_mode[i] == S_DRN) begin
               if (w) begin
                  m_mode[i] = S_ACT; e.nack[i] = 1'b1;
               end else if (id[i]) begin
                  m_mode[i] = S_OFF; m_pd[i] = 1'b1; e.ack[i] = 1'b1;
               end else begin
                  m_budget[i]--;
                  if (m_budget[i] == 0) begin
                     m_mode[i] = S_ACT; e.nack[i] = 1'b1;
                  end
               end
            end else if (m_mode[i] == S_OFF) begin
               if (w) begin
                  m_mode[i] = S_WAK; m_pd[i] = 1'b0; m_budget[i] = SETTLE;
               end
            end else begin
               m_budget[i]--;
               if (m_budget[i] == 0) begin
                  m_mode[i] = S_ACT; e.done[i] = 1'b1;
               end
            end
         end
      end
      e.pd = m_pd;
      for (int i = 0; i < 3; i++) e.st[2*i +: 2] = 2'(m_mode[i]);
      return e;
   endfunction

   // One stimulus cycle: drive at the falling edge, predict, queue.
   task automatic cycle(input logic [2:0] sr, input logic [2:0] id, input logic [2:0] we,
                        input logic cs, input logic rn);
      @(negedge clk_gp_100mhz);
      sleep_req = sr; idle = id; wake_evt = we; clocks_stable = cs;
      if (!rn && rst_n_gp) begin
         rst_n_gp = 1'b0;
         #1;
         chk("async_rst_state", pwr_state, 6'd0);
         chk("async_rst_pd", {3'b0, power_down}, 6'd0);
         chk("async_rst_pulses", {sleep_ack | sleep_nack | wake_done, 3'b0}, 6'd0);
      end
      rst_n_gp = rn;
      q.push_back(model_step(sr, id, we, cs, rn));
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b1);
   endtask

   // Monitor: one expectation per clock edge, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_gp_100mhz);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pwr_state", pwr_state, e.st);
            chk("power_down", {3'b0, power_down}, {3'b0, e.pd});
            chk("sleep_ack", {3'b0, sleep_ack}, {3'b0, e.ack});
            chk("sleep_nack", {3'b0, sleep_nack}, {3'b0, e.nack});
            chk("wake_done", {3'b0, wake_done}, {3'b0, e.done});
         end
      end
   end

   // Driver: directed scenarios then randomized traffic.
   initial begin
      rst_n_gp = 1'b0; clocks_stable = 1'b1;
      sleep_req = '0; idle = '0; wake_evt = '0;
      for (int i = 0; i < 3; i++) begin
         m_mode[i] = S_ACT; m_budget[i] = 0;
      end
      m_pd = '0;
      cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
      cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
      idle_cycles(2);

      // RT sleep, idle three cycles later
      cycle(3'b001, 3'b000, 3'b000, 1'b1, 1'b1);
      idle_cycles(2);
      cycle(3'b000, 3'b001, 3'b000, 1'b1, 1'b1);
      idle_cycles(2);
      // GP drain timeout
      cycle(3'b010, 3'b000, 3'b000, 1'b1, 1'b1);
      idle_cycles(10);
      // RT wake from OFF
      cycle(3'b000, 3'b000, 3'b001, 1'b1, 1'b1);
      idle_cycles(20);
      // PERIPH refused while GP active, then allowed, then GP wake drags PERIPH
      cycle(3'b100, 3'b000, 3'b000, 1'b1, 1'b1);
      cycle(3'b011, 3'b000, 3'b000, 1'b1, 1'b1);
      cycle(3'b000, 3'b011, 3'b000, 1'b1, 1'b1);
      cycle(3'b100, 3'b000, 3'b000, 1'b1, 1'b1);
      cycle(3'b000, 3'b100, 3'b000, 1'b1, 1'b1);
      idle_cycles(1);
      cycle(3'b000, 3'b000, 3'b010, 1'b1, 1'b1);
      idle_cycles(20);
      // All OFF, then clocks lost
      cycle(3'b011, 3'b000, 3'b000, 1'b1, 1'b1);
      cycle(3'b000, 3'b011, 3'b000, 1'b1, 1'b1);
      cycle(3'b100, 3'b000, 3'b000, 1'b1, 1'b1);
      cycle(3'b000, 3'b100, 3'b000, 1'b1, 1'b1);
      cycle(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
      cycle(3'b101, 3'b000, 3'b000, 1'b0, 1'b1);
      idle_cycles(3);
      // Reset during WAKE
      cycle(3'b001, 3'b000, 3'b000, 1'b1, 1'b1);
      cycle(3'b000, 3'b001, 3'b000, 1'b1, 1'b1);
      cycle(3'b000, 3'b000, 3'b001, 1'b1, 1'b1);
      idle_cycles(4);
      cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
      idle_cycles(20);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [2:0] sr, id, we;
         logic cs, rn;
         for (int b = 0; b < 3; b++) begin
            sr[b] = ($urandom_range(0, 5) == 0);
            id[b] = ($urandom_range(0, 2) == 0);
            we[b] = ($urandom_range(0, 19) == 0);
         end
         cs = ($urandom_range(0, 149) != 0);
         rn = ($urandom_range(0, 499) != 0);
         cycle(sr, id, we, cs, rn);
      end
      idle_cycles(2);
      @(negedge clk_gp_100mhz);
      @(negedge clk_gp_100mhz);
      chk("queue_drained", 6'(q.size()), 6'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
